mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port memory (sync read, fixed read latency) between two requesters: port 0, the
//  multicycle core's mem interface, and port 1, a loader/debug master.
//  - Round-robin grant, with an optional bounded lock for multi-beat bursts.
//  - Tags each in-flight read and routes read data back to its issuer.
//  - Sits between the core/loader and the memory; the core is stalled (ena low) when gnt0 is low.
// PARAMETERS
//  ADDR_W      32  address width
//  DATA_W      32  data width
//  RD_LATENCY   1  cycles from read issue to valid mem_rd_data (legal 1..4)
//  MAX_LOCK     8  max consecutive locked grants before forced hand-off (legal 2..255)
// PORTS
//  clk            in   1       clock; all state updates on posedge
//  rst            in   1       synchronous, active-high reset
//  req0/req1      in   1       access request; held with addr/we/wdata until gnt
//  we0/we1        in   1       1=write, 0=read
//  lock0/lock1    in   1       keep grant after this beat (burst)
//  addr0/addr1    in   ADDR_W  request address
//  wdata0/wdata1  in   DATA_W  write data
//  gnt0/gnt1      out  1       comb; access issued to memory this cycle
//  rvalid0/rvalid1 out 1       read data valid for this port
//  rdata0/rdata1  out  DATA_W  read data (= mem_rd_data; qualify with rvalid)
//  mem_addr       out  ADDR_W  memory address
//  mem_wr_data    out  DATA_W  memory write data
//  mem_wr_ena     out  1       memory write strobe
//  mem_rd_data    in   DATA_W  memory read data, RD_LATENCY cycles after address
//  busy           out  1       any read in flight or any grant this cycle
// BEHAVIOUR
//  - At most one beat is issued per cycle; gnt0 & gnt1 is never 1.
//  - Grant: gntN = reqN & selected(N). Selection order:
//    1) If lock_owner_valid and lock_owner is requesting and lock_cnt < MAX_LOCK, grant lock_owner.
//    2) Else if exactly one port requests, grant it.
//    3) Else if both request, grant !last_grant; a lock that hit MAX_LOCK loses to the other port here.
//  - Mux: mem_addr/mem_wr_data/mem_wr_ena follow the granted port; mem_wr_ena = gntN & weN.
//    No grant: mem_addr=0, mem_wr_data=0, mem_wr_ena=0.
//  - Registers updated on a grant to port N:
//    - last_grant <= N.
//    - If lockN: lock_owner <= N, lock_owner_valid <= 1, lock_cnt <= (same owner ? lock_cnt+1 : 1),
//      saturating at MAX_LOCK.
//    - Else: lock_owner_valid <= 0, lock_cnt <= 0.
//  - Forced hand-off: if the other port is granted, lock_owner_valid <= 0, lock_cnt <= 0.
//  - Lock release: if the owner drops req in a cycle, lock_owner_valid <= 0 at the next edge.
//  - Read tracking: RD_LATENCY-deep shift pipe of {valid, id}. valid = gnt & ~we, id = granted port.
//    - rvalidN = pipe_out.valid & (pipe_out.id == N), aligned with mem_rd_data.
//    - Writes never produce rvalid.
//  - Back-to-back reads are fully pipelined (1 beat/cycle); no extra bubble between ports.
//  - Simultaneous: a new issue in the same cycle as a read return is legal; both happen.
//  - Reset (including mid-transfer): last_grant=1 (port 0 wins the first tie), lock_owner_valid=0,
//    lock_cnt=0, pipe cleared. In-flight reads are dropped and never report rvalid.
//    gnt*/rvalid*/mem_wr_ena are 0 while rst=1, regardless of req.
//  - busy = |pipe.valid | gnt0 | gnt1.
// TESTING
//  1) req0 only, read addr 0x10, RD_LATENCY=1 -> gnt0=1 cyc0, mem_addr=0x10, rvalid0=1 cyc1
//     with mem data; rvalid1 never.
//  2) req0&req1 held 4 cyc, no lock, after reset -> grants 0,1,0,1; mem_addr alternates addr0/addr1.
//  3) req1+lock1 with req0 held, MAX_LOCK=3 -> gnt1 x3, gnt0 x1, then gnt1 again.
//  4) RD_LATENCY=3: reads p0 @0x4, p1 @0x8, p0 @0xC on consecutive cycles
//     -> rvalid0, rvalid1, rvalid0 on cyc3..5, matching data.
//  5) p1 write we1=1 addr 0x20 data 0xDEADBEEF -> mem_wr_ena=1 one cycle, correct bus, no rvalid.
//  6) rst asserted with 2 reads in flight -> no rvalid afterward; the first tie post-reset grants port 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port, synchronous-read memory between two requesters
// (port 0: core mem interface, port 1: loader/debug master). Round-robin
// grant with an optional bounded lock for bursts; every read is tagged with
// its issuing port and the returning data is flagged back to that port.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   reqN/weN/lockN           request, write enable, keep-grant-for-burst
//   addrN/wdataN             request address / write data
//   gntN                     combinational: beat issued to memory this cycle
//   rvalidN/rdataN           read data return for port N (rdataN = mem_rd_data)
//   mem_addr/mem_wr_data     memory address / write data of the granted beat
//   mem_wr_ena               memory write strobe
//   mem_rd_data              memory read data, RD_LATENCY cycles after address
//   busy                     a read is in flight or a beat is issued this cycle
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int RD_LATENCY = 1,   // legal 1..4
   parameter int MAX_LOCK   = 8    // legal 2..255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic              lock0,
   input  logic              lock1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wr_data,
   output logic              mem_wr_ena,
   input  logic [DATA_W-1:0] mem_rd_data,
   output logic              busy
);

   localparam logic [7:0] MAX_LOCK_C = 8'(MAX_LOCK);

   logic                  last_grant;        // port granted most recently
   logic                  lock_owner;
   logic                  lock_owner_valid;
   logic [7:0]            lock_cnt;          // consecutive locked grants of lock_owner
   logic [RD_LATENCY-1:0] pipe_valid;        // read in flight, stage 0 = newest
   logic [RD_LATENCY-1:0] pipe_id;           // issuing port of each in-flight read

   logic sel;            // port that wins if it requests
   logic lock_hold;      // lock owner keeps the memory this cycle
   logic lock_spent;     // lock owner has used up its MAX_LOCK beats
   logic any_gnt;
   logic gnt_we;
   logic gnt_lock;

   // Grant selection.
   always_comb begin
      // NOTE: every variable gets a default first, so no path can infer a latch.
      sel        = 1'b0;
      lock_hold  = lock_owner_valid && (lock_owner ? req1 : req0) && (lock_cnt < MAX_LOCK_C);
      lock_spent = lock_owner_valid && (lock_cnt >= MAX_LOCK_C);
      if (lock_hold)
         sel = lock_owner;
      else if (req0 ^ req1)
         sel = req1;
      else if (lock_spent)
         sel = ~lock_owner;          // exhausted lock hands off to the other port
      else
         sel = ~last_grant;
   end

   assign gnt0    = ~rst & req0 & ~sel;
   assign gnt1    = ~rst & req1 &  sel;
   assign any_gnt = gnt0 | gnt1;
   assign gnt_we  = gnt1 ? we1   : we0;
   assign gnt_lock = gnt1 ? lock1 : lock0;

   // Memory-side mux: idle bus is all zeros.
   assign mem_addr    = gnt0 ? addr0  : (gnt1 ? addr1  : '0);
   assign mem_wr_data = gnt0 ? wdata0 : (gnt1 ? wdata1 : '0);
   assign mem_wr_ena  = (gnt0 & we0) | (gnt1 & we1);

   // Read return routing; data is passed straight through, rvalid qualifies it.
   assign rvalid0 = ~rst & pipe_valid[RD_LATENCY-1] & ~pipe_id[RD_LATENCY-1];
   assign rvalid1 = ~rst & pipe_valid[RD_LATENCY-1] &  pipe_id[RD_LATENCY-1];
   assign rdata0  = mem_rd_data;
   assign rdata1  = mem_rd_data;

   assign busy = (|pipe_valid) | any_gnt;

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant       <= 1'b1;   // port 0 wins the first tie
         lock_owner       <= 1'b0;
         lock_owner_valid <= 1'b0;
         lock_cnt         <= '0;
         // NOTE: only the valid bits matter for correctness; ids are cleared
         // too so the pipe never carries X into the routing logic.
         pipe_valid       <= '0;
         pipe_id          <= '0;
      end else begin
         if (any_gnt) begin
            last_grant <= gnt1;
            if (gnt_lock) begin
               lock_owner       <= gnt1;
               lock_owner_valid <= 1'b1;
               if (lock_owner_valid && (lock_owner == gnt1))
                  lock_cnt <= (lock_cnt >= MAX_LOCK_C) ? MAX_LOCK_C : 8'(lock_cnt + 8'd1);
               else
                  lock_cnt <= 8'd1;
            end else begin
               lock_owner_valid <= 1'b0;
               lock_cnt         <= '0;
            end
         end else begin
            // No grant means nobody requested, so the owner dropped its request.
            lock_owner_valid <= 1'b0;
            lock_cnt         <= '0;
         end

         pipe_valid[0] <= any_gnt & ~gnt_we;
         pipe_id[0]    <= gnt1;
         for (int i = 1; i < RD_LATENCY; i++) begin
            pipe_valid[i] <= pipe_valid[i-1];
            pipe_id[i]    <= pipe_id[i-1];
         end
      end
   end

endmodule
